// File: rtl/descrambler_pkg.sv
// Shared constants and state encoding for the 802.11a x^7+x^4+1 descrambler.
package descrambler_pkg;

  localparam int unsigned SYNC_LEN = 7;
  localparam int unsigned LFSR_W   = 7;
  localparam int unsigned TAP_A    = 6;
  localparam int unsigned TAP_B    = 3;

  localparam logic [LFSR_W-1:0] INIT_ALL_ONES = 7'h7F;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSync = 2'd1,
    StData = 2'd2
  } state_e;

endpackage

// File: rtl/descrambler_lfsr.sv
// 7-bit LFSR: load_i shifts in a raw received bit, step_i shifts in its own feedback.
module descrambler_lfsr
  import descrambler_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              bit_i,
  output logic              f_o,
  output logic [LFSR_W-1:0] s_o
);

  logic [LFSR_W-1:0] s_q, s_d;

  assign f_o = s_q[TAP_A] ^ s_q[TAP_B];

  always_comb begin
    s_d = s_q;
    if (load_i) begin
      s_d = {s_q[LFSR_W-2:0], bit_i};
    end else if (step_i) begin
      s_d = {s_q[LFSR_W-2:0], f_o};
    end
  end

  // Post-update state, so the top can capture the seed on the edge that completes sync.
  assign s_o = s_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/descrambler.sv
// Self-synchronising 802.11a descrambler: recovers the seed from 7 sync bits, then descrambles.
module descrambler
  import descrambler_pkg::*;
#(
  parameter bit EMIT_SYNC  = 1'b1,
  parameter bit CHECK_SEED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_bit,
  input  logic              in_valid,
  input  logic              in_start,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [LFSR_W-1:0] seed,
  output logic              seed_valid,
  output logic              seed_err,
  output logic              frame_err
);

  state_e            state_q, state_d;
  logic [2:0]        count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic              out_bit_q, out_bit_d;
  logic              out_last_q, out_last_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic              seed_valid_q, seed_valid_d;
  logic              seed_err_q, seed_err_d;
  logic              frame_err_q, frame_err_d;

  logic              xfer;
  logic              lfsr_load, lfsr_step, lfsr_f;
  logic [LFSR_W-1:0] lfsr_s;

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  descrambler_lfsr u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (lfsr_load),
    .step_i (lfsr_step),
    .bit_i  (in_bit),
    .f_o    (lfsr_f),
    .s_o    (lfsr_s)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_bit_d    = out_bit_q;
    out_last_d   = out_last_q;
    seed_d       = seed_q;
    seed_valid_d = seed_valid_q;
    seed_err_d   = 1'b0;
    frame_err_d  = 1'b0;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;

    if (xfer) begin
      if (in_start) begin
        // A start always begins a new sync; mid-frame or single-bit frames are errors.
        lfsr_load    = 1'b1;
        count_d      = 3'd1;
        seed_valid_d = 1'b0;
        frame_err_d  = (state_q != StIdle) || in_last;
        state_d      = in_last ? StIdle : StSync;
        if (EMIT_SYNC) begin
          out_valid_d = 1'b1;
          out_bit_d   = 1'b0;
          out_last_d  = in_last;
        end
      end else begin
        case (state_q)
          StSync: begin
            lfsr_load = 1'b1;
            if (EMIT_SYNC) begin
              out_valid_d = 1'b1;
              out_bit_d   = 1'b0;
              out_last_d  = in_last;
            end
            if (in_last) begin
              frame_err_d = 1'b1;
              state_d     = StIdle;
            end else begin
              count_d = count_q + 3'd1;
              if (count_q == 3'(SYNC_LEN - 1)) begin
                state_d      = StData;
                seed_d       = lfsr_s;
                seed_valid_d = 1'b1;
                seed_err_d   = CHECK_SEED && (lfsr_s == '0);
              end
            end
          end
          StData: begin
            lfsr_step   = 1'b1;
            out_valid_d = 1'b1;
            out_bit_d   = in_bit ^ lfsr_f;
            out_last_d  = in_last;
            if (in_last) begin
              state_d      = StIdle;
              seed_valid_d = 1'b0;
            end
          end
          default: begin
            state_d = StIdle;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_last_q   <= 1'b0;
      seed_q       <= '0;
      seed_valid_q <= 1'b0;
      seed_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_bit_q    <= out_bit_d;
      out_last_q   <= out_last_d;
      seed_q       <= seed_d;
      seed_valid_q <= seed_valid_d;
      seed_err_q   <= seed_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign out_last   = out_last_q;
  assign seed       = seed_q;
  assign seed_valid = seed_valid_q;
  assign seed_err   = seed_err_q;
  assign frame_err  = frame_err_q;

endmodule
